// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: instruction address type and the redirect controller state
// encoding (exported so debug probes can decode it).
package cpu_defs;

   localparam int INST_ADDR_W = 32;

   typedef logic [INST_ADDR_W-1:0] InstAddr_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_DS = 2'd1,
      ST_PENDING = 2'd2
   } RedirState_t;

endpackage

// File: rtl/pc_redirect_stat.sv
// Redirect statistics counters: redirects issued, delay-slot wait cycles and held
// pending cycles. Only instantiated when PC_REDIRECT_STAT_EN is defined.
module pc_redirect_stat
   import cpu_defs::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  RedirState_t          state_i,
   input  logic                 jump_i,
   input  logic                 hold_pc_i,
   output logic [CNT_WIDTH-1:0] stat_redirects_o,
   output logic [CNT_WIDTH-1:0] stat_ds_wait_o,
   output logic [CNT_WIDTH-1:0] stat_held_o
);

   logic [CNT_WIDTH-1:0] redirects_q, ds_wait_q, held_q;

   // Counters wrap naturally and deliberately ignore except_flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         redirects_q <= '0;
         ds_wait_q   <= '0;
         held_q      <= '0;
      end else begin
         if (jump_i)
            redirects_q <= redirects_q + 1'b1;
         if (state_i == ST_WAIT_DS)
            ds_wait_q <= ds_wait_q + 1'b1;
         if ((state_i == ST_PENDING) && hold_pc_i)
            held_q <= held_q + 1'b1;
      end
   end

   assign stat_redirects_o = redirects_q;
   assign stat_ds_wait_o   = ds_wait_q;
   assign stat_held_o      = held_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Sequences branch/jump redirects into the fetch PC register after the delay slot is
// fetched. Optional statistics counters under macro PC_REDIRECT_STAT_EN.
module pc_redirect_ctrl
   import cpu_defs::*;
#(
   parameter int ADDR_WIDTH = INST_ADDR_W,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_stall,
   input  logic                  pipe_stall,
   input  logic                  except_flush,
   input  logic                  br_req,
   input  logic [ADDR_WIDTH-1:0] br_target,
   output logic                  br_ready,
   input  logic                  ds_fetched,
   output logic                  hold_pc,
   output logic                  jump,
   output logic [ADDR_WIDTH-1:0] jump_to,
   output logic                  redirect_pending
`ifdef PC_REDIRECT_STAT_EN
   ,
   output logic [CNT_WIDTH-1:0]  stat_redirects,
   output logic [CNT_WIDTH-1:0]  stat_ds_wait,
   output logic [CNT_WIDTH-1:0]  stat_held
`endif
);

   if (ADDR_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_chk
      $error("pc_redirect_ctrl: ADDR_WIDTH and CNT_WIDTH must be positive");
   end

   RedirState_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
   logic                  accept;

   assign hold_pc          = fetch_stall | pipe_stall;
   assign br_ready         = (state_q == ST_IDLE) & ~except_flush;
   assign accept           = br_req & br_ready;
   assign jump             = (state_q == ST_PENDING) & ~hold_pc & ~except_flush;
   assign jump_to          = tgt_q;
   assign redirect_pending = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      if (accept)
         tgt_d = br_target;
      // A flush wins over every transition; the buffered target becomes irrelevant.
      if (except_flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (accept) state_d = ds_fetched ? ST_PENDING : ST_WAIT_DS;
            ST_WAIT_DS: if (ds_fetched) state_d = ST_PENDING;
            ST_PENDING: if (jump) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

`ifdef PC_REDIRECT_STAT_EN
   pc_redirect_stat #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_stat (
      .clk              (clk),
      .rst              (rst),
      .state_i          (state_q),
      .jump_i           (jump),
      .hold_pc_i        (hold_pc),
      .stat_redirects_o (stat_redirects),
      .stat_ds_wait_o   (stat_ds_wait),
      .stat_held_o      (stat_held)
   );
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl; redirect targets go through a scoreboard queue
// that is filled on acceptance and drained when jump fires.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_stall, pipe_stall, except_flush;
   logic        br_req, ds_fetched;
   logic [31:0] br_target;
   logic        br_ready, hold_pc, jump, redirect_pending;
   logic [31:0] jump_to;
`ifdef PC_REDIRECT_STAT_EN
   logic [31:0] stat_redirects, stat_ds_wait, stat_held;
`endif

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   pc_redirect_ctrl #(
      .ADDR_WIDTH(32),
      .CNT_WIDTH (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_stall      (fetch_stall),
      .pipe_stall       (pipe_stall),
      .except_flush     (except_flush),
      .br_req           (br_req),
      .br_target        (br_target),
      .br_ready         (br_ready),
      .ds_fetched       (ds_fetched),
      .hold_pc          (hold_pc),
      .jump             (jump),
      .jump_to          (jump_to),
      .redirect_pending (redirect_pending)
`ifdef PC_REDIRECT_STAT_EN
      ,
      .stat_redirects   (stat_redirects),
      .stat_ds_wait     (stat_ds_wait),
      .stat_held        (stat_held)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // jump_to must equal the oldest outstanding accepted target while it waits.
   task automatic chk_tgt(input string tag);
      if (exp_q.size() > 0) chk(tag, jump_to, exp_q[0]);
   endtask

   // One clock cycle: drive inputs, check combinational outputs, then advance.
   task automatic step(input string tag, input logic br, input logic [31:0] tgt,
                       input logic ds, input logic fs, input logic ps, input logic fl,
                       input logic e_rdy, input logic e_jmp, input logic e_pnd);
      logic [31:0] t;
      br_req = br; br_target = tgt; ds_fetched = ds;
      fetch_stall = fs; pipe_stall = ps; except_flush = fl;
      #1;
      chk({tag, ".br_ready"}, {31'b0, br_ready}, {31'b0, e_rdy});
      chk({tag, ".jump"}, {31'b0, jump}, {31'b0, e_jmp});
      chk({tag, ".pending"}, {31'b0, redirect_pending}, {31'b0, e_pnd});
      chk({tag, ".hold_pc"}, {31'b0, hold_pc}, {31'b0, fs | ps});
      if (e_jmp) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s.scoreboard observed=jump expected=no_outstanding_target", tag);
         end else begin
            t = exp_q.pop_front();
            chk({tag, ".jump_to"}, jump_to, t);
         end
      end
      if (br && e_rdy) exp_q.push_back(tgt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      br_req = 1'b0; br_target = '0; ds_fetched = 1'b0;
      fetch_stall = 1'b0; pipe_stall = 1'b0; except_flush = 1'b0;
      @(posedge clk);
      #1;

      // Reset held: idle outputs every cycle, target register cleared.
      step("rst0", 0, 32'h0, 0, 0, 0, 0, 1, 0, 0);
      step("rst1", 0, 32'h0, 0, 1, 0, 0, 1, 0, 0);
      step("rst2", 0, 32'h0, 0, 0, 1, 0, 1, 0, 0);
      chk("rst.jump_to", jump_to, 32'h0);
      rst = 1'b0;

      // Fast path: delay slot already fetched, jump the next cycle only.
      step("fast.acc",  1, 32'hBFC0_0100, 1, 0, 0, 0, 1, 0, 0);
      step("fast.jmp",  0, 32'h0,         0, 0, 0, 0, 0, 1, 1);
      step("fast.idle", 0, 32'h0,         0, 0, 0, 0, 1, 0, 0);

      // Wait for the delay slot for three cycles.
      step("ds.acc", 1, 32'hA000_0040, 0, 0, 0, 0, 1, 0, 0);
      step("ds.w1",  0, 32'h0,         0, 0, 0, 0, 0, 0, 1);
      step("ds.w2",  0, 32'h0,         0, 0, 0, 0, 0, 0, 1);
      step("ds.w3",  0, 32'h0,         1, 0, 0, 0, 0, 0, 1);
      step("ds.jmp", 0, 32'h0,         0, 0, 0, 0, 0, 1, 1);
      step("ds.idl", 0, 32'h0,         0, 0, 0, 0, 1, 0, 0);

      // Stalled pending redirect; a competing br_req must not disturb the target.
      step("stl.acc", 1, 32'h8000_1235, 1, 1, 0, 0, 1, 0, 0);
      chk_tgt("stl.tgt0");
      step("stl.h1",  1, 32'h1111_1111, 0, 1, 0, 0, 0, 0, 1);
      step("stl.h2",  1, 32'h2222_2222, 0, 1, 0, 0, 0, 0, 1);
      chk_tgt("stl.tgt2");
      step("stl.h3",  0, 32'h0,         0, 0, 1, 0, 0, 0, 1);
      step("stl.h4",  0, 32'h0,         0, 1, 1, 0, 0, 0, 1);
      step("stl.h5",  0, 32'h0,         0, 1, 0, 0, 0, 0, 1);
      chk_tgt("stl.tgt5");
      step("stl.jmp", 0, 32'h0,         0, 0, 0, 0, 0, 1, 1);
      step("stl.idl", 0, 32'h0,         0, 0, 0, 0, 1, 0, 0);

      // Flush in PENDING together with a new request; request re-presented afterwards.
      step("fl.acc",  1, 32'h0040_0000, 1, 0, 0, 0, 1, 0, 0);
      step("fl.hit",  1, 32'h0040_0800, 1, 0, 0, 1, 0, 0, 1);
      exp_q.delete();
      step("fl.re",   1, 32'h0040_0800, 1, 0, 0, 0, 1, 0, 0);
      step("fl.jmp",  0, 32'h0,         0, 0, 0, 0, 0, 1, 1);
      step("fl.idl",  0, 32'h0,         0, 0, 0, 0, 1, 0, 0);

      // Flush while waiting for the delay slot.
      step("flw.acc", 1, 32'h0000_0003, 0, 0, 0, 0, 1, 0, 0);
      step("flw.hit", 0, 32'h0,         1, 0, 0, 1, 0, 0, 1);
      exp_q.delete();
      step("flw.idl", 0, 32'h0,         1, 0, 0, 0, 1, 0, 0);
      step("flw.chk", 0, 32'h0,         0, 0, 0, 0, 1, 0, 0);

      // Reset while PENDING (held so jump cannot fire in the reset cycle).
      step("rm.acc",  1, 32'hDEAD_BEE0, 1, 1, 0, 0, 1, 0, 0);
      rst = 1'b1;
      step("rm.rst",  0, 32'h0,         0, 1, 0, 0, 0, 0, 1);
      rst = 1'b0;
      exp_q.delete();
      chk("rm.jump_to", jump_to, 32'h0);
      step("rm.idl",  0, 32'h0,         0, 0, 0, 0, 1, 0, 0);
      step("rm.idl2", 0, 32'h0,         0, 0, 0, 0, 1, 0, 0);

`ifdef PC_REDIRECT_STAT_EN
      rst = 1'b1;
      step("st.rst", 0, 32'h0, 0, 0, 0, 0, 1, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step("st.acc", 1, 32'h0001_0000 + 32'(i * 4), 0, 0, 0, 0, 1, 0, 0);
         step("st.w1",  0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
         step("st.w2",  0, 32'h0, 1, 0, 0, 0, 0, 0, 1);
         step("st.jmp", 0, 32'h0, 0, 0, 0, 0, 0, 1, 1);
      end
      chk("st.redirects", stat_redirects, 32'd4);
      chk("st.ds_wait",   stat_ds_wait,   32'd8);
      chk("st.held",      stat_held,      32'd0);
`endif

      chk("end.scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
